// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO divider: FSM state encoding, handshake
// level names and default widths.
package hilo_div_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RESULT_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-division iteration on the {partial remainder, dividend/quotient}
// working register: shift left, trial-subtract the divisor, keep the
// difference and shift in a 1 when it is non-negative, else shift in a 0.
module hilo_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W:0]  work_i,
  input  logic [DATA_W-1:0]  divisor_i,
  output logic [2*DATA_W:0]  work_o
);
  import hilo_div_pkg::*;

  // Partial remainder never reaches 2^DATA_W, so the top bit is always 0.
  logic              unused_msb;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-2:0] quo_sh;
  logic [DATA_W+1:0] diff;
  logic              qbit;

  assign unused_msb = work_i[2*DATA_W];
  assign rem_sh     = work_i[2*DATA_W-1:DATA_W-1];
  assign quo_sh     = work_i[DATA_W-2:0];

  // Extra bit on the difference carries the borrow, i.e. the trial sign.
  always_comb begin
    diff   = {1'b0, rem_sh} - {2'b00, divisor_i};
    qbit   = ~diff[DATA_W+1];
    work_o = {(qbit ? diff[DATA_W:0] : rem_sh), quo_sh, qbit};
  end

endmodule

// File: rtl/hilo_div.sv
// Multi-cycle DIV/DIVU unit producing {HI = remainder, LO = quotient}.
// Define HILO_DIV_SIGNED_EN to honour signed_div_i (magnitude conversion and
// sign correction); otherwise every operation is unsigned with equal latency.
module hilo_div #(
  parameter int unsigned DATA_W = hilo_div_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  import hilo_div_pkg::*;

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  div_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*DATA_W:0]   work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [2*DATA_W:0]   step_work;
  logic [DATA_W-1:0]   dvd_mag, dvs_mag;
  logic [DATA_W-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

  assign quo_raw = work_q[DATA_W-1:0];
  assign rem_raw = work_q[2*DATA_W-1:DATA_W];

`ifdef HILO_DIV_SIGNED_EN
  logic dvd_neg, dvs_neg;
  logic rem_neg_q, rem_neg_d, quo_neg_q, quo_neg_d;

  assign dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign dvs_neg = signed_div_i & opdata2_i[DATA_W-1];
  // Magnitude of the most negative value wraps to itself, read as unsigned.
  assign dvd_mag = dvd_neg ? ('0 - opdata1_i) : opdata1_i;
  assign dvs_mag = dvs_neg ? ('0 - opdata2_i) : opdata2_i;
  assign quo_fix = quo_neg_q ? ('0 - quo_raw) : quo_raw;
  assign rem_fix = rem_neg_q ? ('0 - rem_raw) : rem_raw;

  // Sign flags captured on the accepting edge drive the final correction.
  always_comb begin
    rem_neg_d = rem_neg_q;
    quo_neg_d = quo_neg_q;
    if (state_q == DivFree && start_i == DivStart && !annul_i) begin
      rem_neg_d = dvd_neg;
      quo_neg_d = dvd_neg ^ dvs_neg;
    end
  end

  // Sign flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
    end else begin
      rem_neg_q <= rem_neg_d;
      quo_neg_q <= quo_neg_d;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_div_i;
  assign dvd_mag       = opdata1_i;
  assign dvs_mag       = opdata2_i;
  assign quo_fix       = quo_raw;
  assign rem_fix       = rem_raw;
`endif

  hilo_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_work)
  );

  // Next-state and datapath control; annul overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    ready_d   = ready_q;
    if (annul_i) begin
      state_d  = DivFree;
      result_d = '0;
      ready_d  = DivResultNotReady;
    end else begin
      unique case (state_q)
        DivFree: begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          if (start_i == DivStart) begin
            divisor_d = dvs_mag;
            if (opdata2_i == '0) begin
              state_d = DivByZero;
            end else begin
              state_d = DivOn;
              cnt_d   = '0;
              work_d  = {{(DATA_W + 1){1'b0}}, dvd_mag};
            end
          end
        end
        DivByZero: begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
        DivOn: begin
          if (cnt_q == CntW'(DATA_W)) begin
            state_d  = DivEnd;
            result_d = {rem_fix, quo_fix};
            ready_d  = DivResultReady;
          end else begin
            work_d = step_work;
            cnt_d  = cnt_q + CntW'(1);
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state_d  = DivFree;
            result_d = '0;
            ready_d  = DivResultNotReady;
          end
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_hilo_div.sv
// Directed self-checking bench for hilo_div (DATA_W = 32).
module tb_hilo_div;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           annul_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  hilo_div dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a division, scramble operands after the accepting edge, and check
  // that ready rises exactly after edge 'lat' with the expected result.
  task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int lat, input logic [63:0] exp);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    opdata1_i    = ~a;
    opdata2_i    = '0;
    signed_div_i = ~sgn;
    repeat (lat - 2) tick();
    check({tag, " early"}, 64'(ready_o), 64'd0);
    tick();
    check({tag, " ready"}, 64'(ready_o), 64'd1);
    check({tag, " result"}, result_o, exp);
  endtask

  task automatic release_start(input string tag);
    start_i = 1'b0;
    tick();
    check({tag, " drop ready"}, 64'(ready_o), 64'd0);
    check({tag, " drop result"}, result_o, 64'd0);
  endtask

`ifdef HILO_DIV_SIGNED_EN
  localparam logic [63:0] ExpNeg7By2   = 64'hFFFFFFFF_FFFFFFFD;
  localparam logic [63:0] ExpMinByNeg1 = 64'h00000000_80000000;
  localparam logic [63:0] Exp100ByNeg7 = 64'h00000002_FFFFFFF2;
`else
  localparam logic [63:0] ExpNeg7By2   = 64'h00000001_7FFFFFFC;
  localparam logic [63:0] ExpMinByNeg1 = 64'h80000000_00000000;
  localparam logic [63:0] Exp100ByNeg7 = 64'h00000064_00000000;
`endif

  initial begin
    logic seen;
    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    tick();
    tick();
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b1;
    tick();

    // Unsigned 7/2 with start held five extra cycles in END.
    run_div("u7by2", 1'b0, 32'd7, 32'd2, 34, 64'h00000001_00000003);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold ready", 64'(ready_o), 64'd1);
      check("hold result", result_o, 64'h00000001_00000003);
    end
    release_start("u7by2");

    run_div("s-7by2", 1'b1, 32'hFFFFFFF9, 32'd2, 34, ExpNeg7By2);
    release_start("s-7by2");

    run_div("byzero", 1'b1, 32'h12345678, 32'd0, 2, 64'd0);
    release_start("byzero");

    run_div("minby-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, ExpMinByNeg1);
    release_start("minby-1");

    run_div("s100by-7", 1'b1, 32'd100, 32'hFFFFFFF9, 34, Exp100ByNeg7);
    release_start("s100by-7");

    // Annul while sitting in END with start still high.
    run_div("udeadbeef", 1'b0, 32'hDEADBEEF, 32'h00001234, 34, 64'h0000076B_000C3BA5);
    annul_i = 1'b1;
    tick();
    check("annul end ready", 64'(ready_o), 64'd0);
    check("annul end result", result_o, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();

    // Annul when the counter reaches 10.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    check("annul mid ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) seen = 1'b1;
    end
    check("annul never ready", 64'(seen), 64'd0);
    check("annul result", result_o, 64'd0);

    // Reset at iteration 20, then a fresh operation completes normally.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (20) tick();
    rst = 1'b0;
    tick();
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst result", result_o, 64'd0);
    rst     = 1'b1;
    start_i = 1'b0;
    tick();
    run_div("u100by7", 1'b0, 32'd100, 32'd7, 34, 64'h00000002_0000000E);
    release_start("u100by7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
